fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter QDEPTH, default 2: instruction queue entries; power of two, at least 2.
REQ-002 SHALL have parameter RESET_PC, default 16'h0000: fetch address after reset.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port stall, input, 1 bit: decode hold; the head entry is not consumed.
REQ-006 SHALL have ports redirect, input, 1 bit, and redirectPC, input, 16 bits: taken branch or jump target from the EX/MEM stage.
REQ-007 SHALL have port halt, input, 1 bit: stop issuing fetches.
REQ-008 SHALL have ports imem_req, output, 1 bit, and imem_addr, output, 16 bits: instruction memory request.
REQ-009 SHALL have ports imem_ack, input, 1 bit, and imem_data, input, 16 bits: instruction memory response.
REQ-010 SHALL have ports instrOut, output, 16 bits; PCOut, output, 16 bits; and validOut, output, 1 bit: queue head toward IF/ID.
REQ-011 SHALL have port err, output, 1 bit: protocol error flag.

Function
REQ-012 SHALL implement states IDLE, REQ, DISCARD and HALTED.
REQ-013 In IDLE, when not halted and (count + outstanding) < QDEPTH, SHALL raise imem_req with imem_addr = fetchPC and enter REQ.
REQ-014 In REQ, SHALL hold imem_req high and imem_addr stable until imem_ack.
REQ-015 On imem_ack in REQ, SHALL push {imem_data, fetchPC+2} and set fetchPC = fetchPC+2 (16'hFFFE wraps to 16'h0000).
REQ-016 After an ack in REQ, SHALL issue the next request in the following cycle when space allows, else return to IDLE; this gives one instruction every cycle with a zero-wait memory.
REQ-017 SHALL drive validOut = queue not empty and instrOut/PCOut = head entry, combinationally from registered state.
REQ-018 SHALL pop the head when validOut is high and stall is low; a push and a pop in the same cycle both take effect.
REQ-019 Queue overflow SHALL be impossible by construction, because the free-slot check counts the outstanding request.
REQ-020 On redirect, SHALL have highest priority: clear the queue at that edge (validOut low next cycle) and set fetchPC = {redirectPC[15:1],1'b0}.
REQ-021 On redirect in REQ without an ack in the same cycle, SHALL enter DISCARD, keep imem_req and the old imem_addr, drop the returning data on ack, then go to IDLE.
REQ-022 On redirect coinciding with imem_ack, SHALL drop the acked data and go to IDLE.
REQ-023 On redirect with stall high, redirect SHALL win.
REQ-024 On halt high, SHALL issue no new requests; an outstanding request SHALL complete and be enqueued (or dropped if in DISCARD), then the block SHALL enter HALTED.
REQ-025 HALTED SHALL be sticky until reset; the queue still drains; redirect updates fetchPC but issues no fetch.
REQ-026 SHALL assert err for one cycle, registered, on odd redirectPC or on imem_ack received in IDLE or HALTED.
REQ-027 SHALL ignore an imem_ack received in IDLE or HALTED, enqueueing nothing.

Reset
REQ-028 When rst is low, SHALL immediately force imem_req=0, validOut=0 and err=0; SHALL force instrOut, PCOut and imem_addr to 0; SHALL set fetchPC=RESET_PC, empty the queue and enter IDLE.
REQ-029 Reset during REQ or DISCARD SHALL abandon the transaction; a later stray ack SHALL follow REQ-026 and REQ-027.
REQ-030 After rst rises, SHALL issue the first request at the first rising edge.

Configuration
REQ-031 With FETCHQ_HALT_PREDECODE_EN defined, an acked instruction with imem_data[15:11]==5'b00000 SHALL be enqueued and SHALL send fetch to HALTED with no further requests.
REQ-032 Without FETCHQ_HALT_PREDECODE_EN, only the halt input SHALL stop fetching.

Verification
REQ-033 Reset release, zero-wait ack each cycle, stall=0 -> PCOut 16'h0002, 16'h0004, 16'h0006 on consecutive cycles; validOut continuous from the second cycle.
REQ-034 stall=1 for 5 cycles with QDEPTH=2 -> at most 2 entries queued, no request issued while full, head instrOut held constant.
REQ-035 Redirect to 16'h0040 while a request to 16'h0008 waits 3 cycles -> 16'h0008 data dropped, next imem_addr 16'h0040, next PCOut 16'h0042.
REQ-036 fetchPC=16'hFFFE, ack -> PCOut 16'h0000 and next imem_addr 16'h0000.
REQ-037 redirectPC=16'h0013 -> err pulses one cycle and imem_addr becomes 16'h0012; ack while IDLE -> err pulses one cycle and nothing is enqueued.
REQ-038 With FETCHQ_HALT_PREDECODE_EN defined, fetch imem_data=16'h0000 -> enqueued, imem_req stays 0 afterwards; without the macro, fetching continues.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch unit feeding a small queue toward IF/ID; latency: one request per cycle with a zero-wait memory,
// head visible the cycle after the ack; backpressure: stall holds the head, requests stop while the queue has no free slot.
// Optional FETCHQ_HALT_PREDECODE_EN: an acked instruction with opcode bits [15:11]==0 halts fetching.
module fetch_queue #(
    parameter int unsigned QDEPTH   = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirectPC,
    input  logic        halt,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] instrOut,
    output logic [15:0] PCOut,
    output logic        validOut,
    output logic        err
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD, HALTED} state_t;

    state_t        state_q;
    logic [15:0]   fetch_pc_q;
    logic [15:0]   imem_addr_q;
    logic          imem_req_q;
    logic          err_q;
    logic          halt_pend_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [15:0]   instr_mem [QDEPTH];
    logic [15:0]   pc_mem    [QDEPTH];

    logic        push;
    logic        pop;
    logic        halt_eff;
    logic        pd_halt;
    logic [15:0] fetch_pc_inc;

`ifdef FETCHQ_HALT_PREDECODE_EN
    assign pd_halt = (imem_data[15:11] == 5'b00000);
`else
    assign pd_halt = 1'b0;
`endif

    assign halt_eff     = halt | halt_pend_q;
    assign fetch_pc_inc = fetch_pc_q + 16'd2;

    // Data acked while a redirect is in flight belongs to the old path and is never stored.
    always_comb begin
        push    = (state_q == REQ) && imem_ack && !redirect;
        pop     = (count_q != '0) && !stall;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_data;
            pc_mem[wr_ptr_q]    <= fetch_pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            imem_addr_q <= 16'h0000;
            imem_req_q  <= 1'b0;
            err_q       <= 1'b0;
            halt_pend_q <= 1'b0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            err_q       <= (redirect && redirectPC[0]) ||
                           (imem_ack && (state_q == IDLE || state_q == HALTED));
            halt_pend_q <= halt_pend_q | halt;

            if (redirect) begin
                count_q    <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
                fetch_pc_q <= {redirectPC[15:1], 1'b0};
            end else begin
                count_q <= count_d;
                if (push) begin
                    wr_ptr_q   <= wr_ptr_q + PW'(1);
                    fetch_pc_q <= fetch_pc_inc;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (halt_eff) begin
                        state_q <= HALTED;
                    end else if (!redirect && count_q < DEPTH_C) begin
                        state_q     <= REQ;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= fetch_pc_q;
                    end
                end
                REQ: begin
                    // count_d already includes this ack's push, so a back-to-back request cannot overflow.
                    if (imem_ack) begin
                        if (halt_eff || (push && pd_halt)) begin
                            state_q    <= HALTED;
                            imem_req_q <= 1'b0;
                        end else if (redirect) begin
                            state_q    <= IDLE;
                            imem_req_q <= 1'b0;
                        end else if (count_d < DEPTH_C) begin
                            imem_req_q  <= 1'b1;
                            imem_addr_q <= fetch_pc_inc;
                        end else begin
                            state_q    <= IDLE;
                            imem_req_q <= 1'b0;
                        end
                    end else if (redirect) begin
                        state_q <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        imem_req_q <= 1'b0;
                        state_q    <= halt_eff ? HALTED : IDLE;
                    end
                end
                default: begin
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign err       = err_q;
    assign validOut  = (count_q != '0);
    assign instrOut  = validOut ? instr_mem[rd_ptr_q] : 16'h0000;
    assign PCOut     = validOut ? pc_mem[rd_ptr_q]    : 16'h0000;

endmodule
